traffic_light: RTL and testbench

TRAFFIC_LIGHT -- requirements
Module: traffic_light

---
 rtl/traffic_light_pkg.sv | 41 ++++
 rtl/traffic_light_timer.sv | 41 ++++
 rtl/traffic_light.sv | 144 ++++++++++++++
 tb/tb_traffic_light.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light controller:
// state encoding, light codes and default dwell times (1 tick = 1 ms).
package traffic_light_pkg;

    typedef enum logic [2:0] {
        S0_RED       = 3'd0,
        S1_RED_AMBER = 3'd1,
        S2_GREEN     = 3'd2,
        S3_AMBER     = 3'd3,
        S4_PED_GREEN = 3'd4
    } tl_state_e;

    // Traffic lights are {red, amber, green}.
    localparam logic [2:0] TL_RED       = 3'b100;
    localparam logic [2:0] TL_RED_AMBER = 3'b110;
    localparam logic [2:0] TL_GREEN     = 3'b001;
    localparam logic [2:0] TL_AMBER     = 3'b010;

    // Pedestrian lights are {red, green}.
    localparam logic [1:0] PL_RED   = 2'b10;
    localparam logic [1:0] PL_GREEN = 2'b01;

    localparam int unsigned DEF_RED_TICKS   = 30000;
    localparam int unsigned DEF_RA_TICKS    = 3000;
    localparam int unsigned DEF_GREEN_TICKS = 30000;
    localparam int unsigned DEF_AMBER_TICKS = 3000;
    localparam int unsigned DEF_PED_TICKS   = 30000;

    function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d,
                                         input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// Dwell-time tick counter. Cleared on every state entry; done flags the
// last tick of the current state (count == limit-1). The counter holds at
// limit-1 rather than wrapping if the state were ever to linger.
module traffic_light_timer #(
    parameter int unsigned CNT_W = 15
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic [CNT_W:0]   limit,
    output logic             done
);

    localparam logic [CNT_W:0]   LIM_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = ({1'b0, cnt_q} == (limit - LIM_ONE));

    // Next count: clear wins, otherwise count up until the last tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light.sv
// Pelican-style traffic light controller with pedestrian request.
// Optional macro PED_BUTTON_SYNC_EN: when defined, button passes through a
// 2-flop synchroniser before the request latch (+2 cycles of latency).
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int unsigned RED_TICKS   = DEF_RED_TICKS,
    parameter int unsigned RA_TICKS    = DEF_RA_TICKS,
    parameter int unsigned GREEN_TICKS = DEF_GREEN_TICKS,
    parameter int unsigned AMBER_TICKS = DEF_AMBER_TICKS,
    parameter int unsigned PED_TICKS   = DEF_PED_TICKS
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       button,
    output logic [2:0] traffic_lights,
    output logic [1:0] pedestrian_lights
);

    localparam int unsigned MAX_TICKS = max5(RED_TICKS, RA_TICKS, GREEN_TICKS,
                                             AMBER_TICKS, PED_TICKS);
    localparam int unsigned CNT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W:0] RED_L   = RED_TICKS[CNT_W:0];
    localparam logic [CNT_W:0] RA_L    = RA_TICKS[CNT_W:0];
    localparam logic [CNT_W:0] GREEN_L = GREEN_TICKS[CNT_W:0];
    localparam logic [CNT_W:0] AMBER_L = AMBER_TICKS[CNT_W:0];
    localparam logic [CNT_W:0] PED_L   = PED_TICKS[CNT_W:0];

    tl_state_e      state_q;
    tl_state_e      state_d;
    logic           req_q;
    logic           req_d;
    logic           button_s;
    logic           tmr_done;
    logic           tmr_clear;
    logic [CNT_W:0] tmr_limit;

`ifdef PED_BUTTON_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for the asynchronous pushbutton.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], button};
        end
    end

    assign button_s = sync_q[1];
`else
    assign button_s = button;
`endif

    // Next-state logic; a pending request shortens red and green but never
    // red/amber or amber, and the pedestrian phase always hands back to S1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0_RED: begin
                if (req_q)         state_d = S4_PED_GREEN;
                else if (tmr_done) state_d = S1_RED_AMBER;
            end
            S1_RED_AMBER: begin
                if (tmr_done) state_d = S2_GREEN;
            end
            S2_GREEN: begin
                if (req_q || tmr_done) state_d = S3_AMBER;
            end
            S3_AMBER: begin
                if (tmr_done) state_d = req_q ? S4_PED_GREEN : S0_RED;
            end
            S4_PED_GREEN: begin
                if (tmr_done) state_d = S1_RED_AMBER;
            end
            default: state_d = S0_RED;
        endcase
    end

    // Request latch: presses merge, ignored during S4, cleared on S4 entry.
    always_comb begin
        req_d = req_q;
        if ((state_d == S4_PED_GREEN) && (state_q != S4_PED_GREEN)) begin
            req_d = 1'b0;
        end else if (button_s && (state_q != S4_PED_GREEN)) begin
            req_d = 1'b1;
        end
    end

    // State and request registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S0_RED;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign tmr_clear = (state_d != state_q);

    // Dwell limit for the current state.
    always_comb begin
        tmr_limit = RED_L;
        case (state_q)
            S0_RED:       tmr_limit = RED_L;
            S1_RED_AMBER: tmr_limit = RA_L;
            S2_GREEN:     tmr_limit = GREEN_L;
            S3_AMBER:     tmr_limit = AMBER_L;
            S4_PED_GREEN: tmr_limit = PED_L;
            default:      tmr_limit = RED_L;
        endcase
    end

    traffic_light_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .nrst  (nrst),
        .clear (tmr_clear),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    // Moore output decode; unused encodings fall back to all-red.
    always_comb begin
        traffic_lights    = TL_RED;
        pedestrian_lights = PL_RED;
        case (state_q)
            S0_RED:       traffic_lights = TL_RED;
            S1_RED_AMBER: traffic_lights = TL_RED_AMBER;
            S2_GREEN:     traffic_lights = TL_GREEN;
            S3_AMBER:     traffic_lights = TL_AMBER;
            S4_PED_GREEN: pedestrian_lights = PL_GREEN;
            default: begin
                traffic_lights    = TL_RED;
                pedestrian_lights = PL_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light with scaled-down dwell times.
module tb_traffic_light;

    localparam int unsigned RED   = 40;
    localparam int unsigned RA    = 6;
    localparam int unsigned GREEN = 40;
    localparam int unsigned AMBER = 6;
    localparam int unsigned PED   = 40;
`ifdef PED_BUTTON_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    localparam logic [2:0] T_R  = 3'b100;
    localparam logic [2:0] T_RA = 3'b110;
    localparam logic [2:0] T_G  = 3'b001;
    localparam logic [2:0] T_A  = 3'b010;
    localparam logic [1:0] P_R  = 2'b10;
    localparam logic [1:0] P_G  = 2'b01;

    logic       clk = 1'b0;
    logic       nrst;
    logic       button;
    logic [2:0] traffic_lights;
    logic [1:0] pedestrian_lights;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned bad_codes = 0;

    traffic_light #(
        .RED_TICKS   (RED),
        .RA_TICKS    (RA),
        .GREEN_TICKS (GREEN),
        .AMBER_TICKS (AMBER),
        .PED_TICKS   (PED)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .button            (button),
        .traffic_lights    (traffic_lights),
        .pedestrian_lights (pedestrian_lights)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            case ({traffic_lights, pedestrian_lights})
                {T_R, P_R}, {T_RA, P_R}, {T_G, P_R}, {T_A, P_R}, {T_R, P_G}: ;
                default: bad_codes++;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp_v, exp_v, $time);
        end
    endtask

    // Called on the first negedge of a phase; returns on the first negedge of the next.
    task automatic run_len(input string tag, input logic [2:0] tl, input logic [1:0] pl,
                           input int unsigned exp_len);
        int unsigned n;
        n = 1;
        check({tag, "_code"}, 32'({traffic_lights, pedestrian_lights}), 32'({tl, pl}));
        while (n < 2000) begin
            @(negedge clk);
            if ({traffic_lights, pedestrian_lights} == {tl, pl}) n++;
            else break;
        end
        check({tag, "_len"}, n, exp_len);
    endtask

    task automatic press_at(input int unsigned delay, input int unsigned len);
        fork
            begin
                repeat (delay) @(negedge clk);
                button = 1'b1;
                repeat (len) @(negedge clk);
                button = 1'b0;
            end
        join_none
    endtask

    task automatic normal_tail;
        run_len("tail_s1", T_RA, P_R, RA);
        run_len("tail_s2", T_G, P_R, GREEN);
        run_len("tail_s3", T_A, P_R, AMBER);
    endtask

    initial begin
        nrst   = 1'b0;
        button = 1'b0;
        #1;
        check("rst_async", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_R}));
        repeat (3) @(negedge clk);
        check("rst_hold", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_R}));
        nrst = 1'b1;

        // Free-running cycle, no requests.
        run_len("free_s0", T_R, P_R, RED);
        run_len("free_s1", T_RA, P_R, RA);
        run_len("free_s2", T_G, P_R, GREEN);
        run_len("free_s3", T_A, P_R, AMBER);

        // Ten-cycle press mid red: S4 one cycle after first high sample.
        repeat (15) @(negedge clk);
        press_at(0, 10);
        repeat (1 + SYNC_LAT) @(negedge clk);
        check("s0_before_ped", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_R}));
        @(negedge clk);
        run_len("s0_ped", T_R, P_G, PED);
        normal_tail();

        // Press mid green cuts green short.
        run_len("g_s0", T_R, P_R, RED);
        run_len("g_s1", T_RA, P_R, RA);
        repeat (15) @(negedge clk);
        press_at(0, 1);
        repeat (1 + SYNC_LAT) @(negedge clk);
        check("g_hold", 32'({traffic_lights, pedestrian_lights}), 32'({T_G, P_R}));
        @(negedge clk);
        run_len("g_amber", T_A, P_R, AMBER);
        run_len("g_ped", T_R, P_G, PED);
        normal_tail();

        // Press in S1 stays pending; S2 lasts one cycle.
        run_len("ra_s0", T_R, P_R, RED);
        press_at(RA / 2, 1);
        run_len("ra_s1", T_RA, P_R, RA);
        run_len("ra_s2", T_G, P_R, 1);
        run_len("ra_s3", T_A, P_R, AMBER);
        run_len("ra_ped", T_R, P_G, PED);
        run_len("ra_s1b", T_RA, P_R, RA);

        // Press on the final green tick: full green, full amber, then S4.
        press_at(GREEN - 1 - SYNC_LAT, 1);
        run_len("last_s2", T_G, P_R, GREEN);
        run_len("last_s3", T_A, P_R, AMBER);
        run_len("last_ped", T_R, P_G, PED);
        run_len("last_s1", T_RA, P_R, RA);

        // Press during amber: amber completes, then S4.
        press_at(GREEN + 2, 1);
        run_len("am_s2", T_G, P_R, GREEN);
        run_len("am_s3", T_A, P_R, AMBER);
        run_len("am_ped", T_R, P_G, PED);
        normal_tail();

        // Rapid pulses plus a press inside S4: one pedestrian phase only.
        press_at(10, 5);
        press_at(17, 5);
        press_at(12 + SYNC_LAT + PED / 2, 1);
        run_len("rap_s0", T_R, P_R, 12 + SYNC_LAT);
        run_len("rap_ped", T_R, P_G, PED);
        normal_tail();

        // Reset with a request pending in S1 drops it.
        run_len("rq_s0", T_R, P_R, RED);
        press_at(0, 1);
        repeat (2 + SYNC_LAT) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("rq_rst", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_R}));
        @(negedge clk);
        nrst = 1'b1;
        run_len("rq_s0b", T_R, P_R, RED);
        normal_tail();

        // Reset in the middle of S4.
        press_at(0, 1);
        run_len("r4_s0", T_R, P_R, 2 + SYNC_LAT);
        repeat (PED / 4) @(negedge clk);
        check("r4_in_ped", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_G}));
        nrst = 1'b0;
        #1;
        check("r4_rst", 32'({traffic_lights, pedestrian_lights}), 32'({T_R, P_R}));
        @(negedge clk);
        nrst = 1'b1;
        run_len("r4_s0b", T_R, P_R, RED);
        run_len("r4_s1", T_RA, P_R, RA);

        check("illegal_codes", bad_codes, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
